// File: rtl/mul4_sequencer.sv
// mul4_sequencer: 4x4 unsigned shift-and-add multiplier.
// One operation is accepted in IDLE and runs four CALC cycles, each doing a
// single 4-bit add and a 9-bit right shift of {C,A,Q}. There is one DONE
// cycle, and after it the block returns to IDLE. The last product is held
// in P.
module mul4_sequencer (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       start_i,
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic       ready_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [7:0] product_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_nxt;

  logic [3:0]  m_q;    // multiplicand
  logic [3:0]  a_q;    // accumulator (high product half)
  logic [3:0]  q_q;    // multiplier, shifts out as low product half fills in
  logic        c_q;    // carry out of the add
  logic [1:0]  cnt_q;  // CALC iteration
  logic [7:0]  p_q;    // last completed product

  logic [4:0]  sum;
  logic [4:0]  acc;
  logic [3:0]  a_shf;
  logic [3:0]  q_shf;
  logic        last_iter;

  // The step's single add. This logic also builds the shifted {C,A,Q}.
  // C is always clear when a CALC edge begins, so {c_q,a_q} is {0,A}.
  always_comb begin
    sum       = {1'b0, a_q} + {1'b0, m_q};
    acc       = q_q[0] ? sum : {c_q, a_q};
    a_shf     = acc[4:1];
    q_shf     = {acc[0], q_q[3:1]};
    last_iter = (cnt_q == 2'd3);
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state: CALC runs a fixed four edges, and DONE is a single cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_i)   state_nxt = CALC;
      CALC:    if (last_iter) state_nxt = DONE;
      DONE:                   state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Outputs decode from the registered state only
  always_comb begin
    ready_o = (state == IDLE);
    busy_o  = (state == CALC) || (state == DONE);
    done_o  = (state == DONE);
  end

  assign product_o = p_q;

  // Datapath: operands load on accept. Each CALC edge adds and shifts.
  // P updates only on the final iteration.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      m_q   <= '0;
      a_q   <= '0;
      q_q   <= '0;
      c_q   <= 1'b0;
      cnt_q <= '0;
      p_q   <= '0;
    end else begin
      case (state)
        IDLE: if (start_i) begin
          m_q   <= a_i;
          q_q   <= b_i;
          a_q   <= '0;
          c_q   <= 1'b0;
          cnt_q <= '0;
        end
        CALC: begin
          a_q   <= a_shf;
          q_q   <= q_shf;
          c_q   <= 1'b0;
          cnt_q <= cnt_q + 2'd1;
          if (last_iter) p_q <= {a_shf, q_shf};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mul4_sequencer.md
MUL4_SEQUENCER -- requirements
Module: mul4_sequencer

Interface
REQ-001 Parameters: none; operand width is fixed at 4 bits.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n_i  input  1  reset; synchronous, active-low.
REQ-004 start_i  input  1  request to multiply; accepted only when ready_o=1.
REQ-005 a_i  input  4  multiplicand, unsigned; sampled on accept.
REQ-006 b_i  input  4  multiplier, unsigned; sampled on accept.
REQ-007 ready_o  output  1  high only in IDLE.
REQ-008 busy_o  output  1  high in CALC and DONE.
REQ-009 done_o  output  1  one-cycle pulse; high only in DONE.
REQ-010 product_o  output  8  last completed product, unsigned.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, CALC, DONE.
REQ-012 Datapath registers SHALL be: M[3:0] multiplicand, A[3:0] accumulator, Q[3:0] multiplier/low product, C carry bit, CNT[1:0] iteration count, P[7:0] result.
REQ-013 The datapath SHALL use exactly one 4-bit add (A + M, carry-in 0) per CALC cycle; no multiply operator.
REQ-014 IDLE, start_i=1 at an edge: load M<=a_i, Q<=b_i, A<=0, C<=0, CNT<=0; go to CALC.
REQ-015 IDLE, start_i=0: stay in IDLE; M, A, Q, CNT, P hold.
REQ-016 Each CALC edge: if Q[0]=1, {C,A} <= A+M with 5-bit result; otherwise {C,A} <= {0,A}; then {C,A,Q} SHALL be shifted right by 1 in the same edge, with C cleared.
REQ-017 CALC SHALL run exactly 4 edges (CNT 0..3), independent of operand values; at the edge with CNT=3, go to DONE and load P <= final {A,Q}.
REQ-018 DONE: lasts exactly one cycle, with done_o=1; the next edge returns to IDLE unconditionally.
REQ-019 Latency: accept edge E0; P is valid and done_o=1 in the cycle after E4; ready_o returns high after E5.
REQ-020 start_i in CALC or DONE SHALL be ignored: no restart, no operand capture, no queuing.
REQ-021 a_i and b_i changes after the accept edge SHALL NOT affect the result in progress.
REQ-022 product_o SHALL equal P, hold its value through IDLE and the following operation, and change only at the CNT=3 edge.
REQ-023 Result SHALL equal a_i*b_i exactly for all 256 operand pairs (max 15*15=225=0xE1; no overflow is possible).
REQ-024 Outputs SHALL decode from registered state only; there is no combinational path from inputs to outputs.

Reset
REQ-025 An edge with rst_n_i=0 SHALL force IDLE, M=A=Q=0, C=0, CNT=0, P=0.
REQ-026 After reset: ready_o=1, busy_o=0, done_o=0, product_o=0x00.
REQ-027 Reset in any state, including mid-CALC or DONE, SHALL abort the operation with no done_o pulse; the partial result is discarded.
REQ-028 Reset has priority over start_i at the same edge.
REQ-029 An asserted rst_n_i with no clock edge SHALL have no effect (synchronous reset).

Verification
REQ-030 Reset, then idle -> ready_o=1, busy_o=0, done_o=0, product_o=0x00.
REQ-031 start_i pulse with a_i=15, b_i=15 at E0 -> busy_o=1 for E0..E5, done_o=1 only in the cycle after E4, product_o=0xE1.
REQ-032 a_i=0, b_i=9 and then a_i=7, b_i=0 -> product_o=0x00 each time; latency and done_o timing are unchanged.
REQ-033 a_i=5, b_i=3, then start_i held high continuously -> first product 0x0F; the next accept occurs at the first edge after ready_o returns high; no start is accepted while busy.
REQ-034 Start with a_i=6, b_i=7, change a_i/b_i to 0xF during CALC -> product_o=0x2A.
REQ-035 Start with a_i=9, b_i=9 following a prior result of 0x0F, rst_n_i=0 at E2 -> no done_o pulse, FSM in IDLE, product_o=0x00.
REQ-036 Exhaustive sweep of all 256 pairs against a reference model -> every product matches, with exactly one done_o pulse per accepted start.
